// File: rtl/node_bit_collector.sv
// node_bit_collector: registers each 8-bit SPC node decision, produces its
// polar partial sums (x = u * F^{x3}) for the upper stages, and packs
// consecutive nodes into a FRAME_LEN-bit frame offered on a valid/ready port.
module node_bit_collector #(
    parameter int FRAME_LEN = 64,
    parameter int NODE_BITS = 8
) (
    input  logic                                  clk_i,
    input  logic                                  rst_n_i,
    input  logic                                  dec_start_i,
    input  logic                                  node_valid_i,
    output logic                                  node_ready_o,
    input  logic [NODE_BITS-1:0]                  node_bits_i,
    output logic                                  psum_valid_o,
    output logic [NODE_BITS-1:0]                  psum_bits_o,
    output logic [$clog2(FRAME_LEN/NODE_BITS):0]  node_cnt_o,
    output logic                                  frame_valid_o,
    input  logic                                  frame_ready_i,
    output logic [FRAME_LEN-1:0]                  frame_bits_o
);

    localparam int SLOTS = FRAME_LEN / NODE_BITS;
    localparam int CNT_W = $clog2(SLOTS) + 1;

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_t;

    state_t                 state_q;
    logic [CNT_W-1:0]       node_cnt_q;
    logic                   frame_valid_q;
    logic [FRAME_LEN-1:0]   frame_bits_q;
    logic                   psum_valid_q;
    logic [NODE_BITS-1:0]   psum_bits_q;
    logic [NODE_BITS-1:0]   psum_d;
    logic [NODE_BITS-1:0]   v;
    logic                   node_accept;
    logic                   frame_accept;

    // A start request wins over both handshakes so an aborted frame never
    // leaks a node write, a partial sum, or a frame hand-off.
    assign node_ready_o = (state_q == COLLECT);
    assign node_accept  = node_valid_i & node_ready_o & ~dec_start_i;
    assign frame_accept = frame_valid_q & frame_ready_i & ~dec_start_i;

    // Butterfly network: v[i] holds u_i, each stage h folds v[i+h] into v[i]
    // for the lower member of every pair, giving x in v after h = 4.
    always_comb begin
        v      = '0;
        psum_d = '0;
        for (int i = 0; i < 8; i++) begin
            v[i] = node_bits_i[7-i];
        end
        for (int s = 0; s < 3; s++) begin
            for (int p = 0; p < 4; p++) begin
                v[((p >> s) << (s + 1)) | (p & ((1 << s) - 1))] =
                    v[((p >> s) << (s + 1)) | (p & ((1 << s) - 1))] ^
                    v[(((p >> s) << (s + 1)) | (p & ((1 << s) - 1))) + (1 << s)];
            end
        end
        for (int i = 0; i < 8; i++) begin
            psum_d[7-i] = v[i];
        end
    end

    // Frame collection state machine with registered partial-sum and frame outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q       <= COLLECT;
            node_cnt_q    <= '0;
            frame_valid_q <= 1'b0;
            frame_bits_q  <= '0;
            psum_valid_q  <= 1'b0;
            psum_bits_q   <= '0;
        end else begin
            psum_valid_q <= node_accept;
            if (node_accept) begin
                psum_bits_q <= psum_d;
            end

            if (dec_start_i) begin
                state_q       <= COLLECT;
                node_cnt_q    <= '0;
                frame_valid_q <= 1'b0;
            end else begin
                case (state_q)
                    COLLECT: begin
                        if (node_valid_i) begin
                            for (int k = 0; k < SLOTS; k++) begin
                                if (node_cnt_q == CNT_W'(k)) begin
                                    frame_bits_q[FRAME_LEN-1-NODE_BITS*k -: NODE_BITS] <= node_bits_i;
                                end
                            end
                            node_cnt_q <= node_cnt_q + CNT_W'(1);
                            if (node_cnt_q == CNT_W'(SLOTS - 1)) begin
                                state_q       <= FULL;
                                frame_valid_q <= 1'b1;
                            end
                        end
                    end
                    FULL: begin
                        if (frame_accept) begin
                            state_q       <= COLLECT;
                            node_cnt_q    <= '0;
                            frame_valid_q <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= COLLECT;
                    end
                endcase
            end
        end
    end

    assign psum_valid_o  = psum_valid_q;
    assign psum_bits_o   = psum_bits_q;
    assign node_cnt_o    = node_cnt_q;
    assign frame_valid_o = frame_valid_q;
    assign frame_bits_o  = frame_bits_q;

endmodule

// File: tb/tb_node_bit_collector.sv
// tb_node_bit_collector: directed and randomized steps checked against a
// queue-based reference model of the node collector.
module tb_node_bit_collector;

    localparam int FRAME_LEN = 64;
    localparam int SLOTS     = FRAME_LEN / 8;
    localparam int CNT_W     = $clog2(SLOTS) + 1;

    logic                  clk;
    logic                  rst_n;
    logic                  dec_start;
    logic                  node_valid;
    logic                  node_ready;
    logic [7:0]            node_bits;
    logic                  psum_valid;
    logic [7:0]            psum_bits;
    logic [CNT_W-1:0]      node_cnt;
    logic                  frame_valid;
    logic                  frame_ready;
    logic [FRAME_LEN-1:0]  frame_bits;

    int checks   = 0;
    int failures = 0;

    // Reference model: nodes collected so far, last value written to each slot,
    // and the partial sum the most recent accepted node should produce.
    logic [7:0] collected[$];
    logic [7:0] slotBytes[SLOTS];
    logic       expPsumValid;
    logic [7:0] expPsum;

    node_bit_collector #(.FRAME_LEN(FRAME_LEN), .NODE_BITS(8)) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .dec_start_i   (dec_start),
        .node_valid_i  (node_valid),
        .node_ready_o  (node_ready),
        .node_bits_i   (node_bits),
        .psum_valid_o  (psum_valid),
        .psum_bits_o   (psum_bits),
        .node_cnt_o    (node_cnt),
        .frame_valid_o (frame_valid),
        .frame_ready_i (frame_ready),
        .frame_bits_o  (frame_bits)
    );

    always #5 clk = ~clk;

    // x_j is the XOR of every u_i whose index i contains all bits of j (x = u*F^{x3}).
    function automatic logic [7:0] refPsum(input logic [7:0] b);
        logic [7:0] r;
        r = '0;
        for (int j = 0; j < 8; j++) begin
            logic x;
            x = 1'b0;
            for (int i = 0; i < 8; i++) begin
                if ((i & j) == j) x = x ^ b[7-i];
            end
            r[7-j] = x;
        end
        return r;
    endfunction

    function automatic logic [FRAME_LEN-1:0] expFrame();
        logic [FRAME_LEN-1:0] f;
        f = '0;
        for (int k = 0; k < SLOTS; k++) f[FRAME_LEN-1-8*k -: 8] = slotBytes[k];
        return f;
    endfunction

    task automatic cmp(input string tag, input logic [FRAME_LEN-1:0] obs, input logic [FRAME_LEN-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        cmp({tag, ".node_ready"},  FRAME_LEN'(node_ready),  FRAME_LEN'(collected.size() < SLOTS));
        cmp({tag, ".node_cnt"},    FRAME_LEN'(node_cnt),    FRAME_LEN'(collected.size()));
        cmp({tag, ".frame_valid"}, FRAME_LEN'(frame_valid), FRAME_LEN'(collected.size() == SLOTS));
        cmp({tag, ".psum_valid"},  FRAME_LEN'(psum_valid),  FRAME_LEN'(expPsumValid));
        cmp({tag, ".psum_bits"},   FRAME_LEN'(psum_bits),   FRAME_LEN'(expPsum));
        cmp({tag, ".frame_bits"},  frame_bits,              expFrame());
    endtask

    // One clock: drive at negedge, advance the model at posedge, check 1 time unit later.
    task automatic applyStimulus(input string tag, input logic rst, input logic start,
                                 input logic valid, input logic [7:0] bits, input logic fready);
        bit full;
        bit acc;
        @(negedge clk);
        rst_n       = ~rst;
        dec_start   = start;
        node_valid  = valid;
        node_bits   = bits;
        frame_ready = fready;
        @(posedge clk);
        if (rst) begin
            collected.delete();
            foreach (slotBytes[k]) slotBytes[k] = 8'h00;
            expPsumValid = 1'b0;
            expPsum      = 8'h00;
        end else begin
            full = (collected.size() == SLOTS);
            acc  = valid && !full && !start;
            expPsumValid = acc;
            if (acc) expPsum = refPsum(bits);
            if (start) begin
                collected.delete();
            end else if (full && fready) begin
                collected.delete();
            end else if (acc) begin
                slotBytes[collected.size()] = bits;
                collected.push_back(bits);
            end
        end
        #1;
        checkOutput(tag);
    endtask

    initial begin
        logic [7:0] psumVec[4];
        clk         = 1'b0;
        rst_n       = 1'b1;
        dec_start   = 1'b0;
        node_valid  = 1'b0;
        node_bits   = 8'h00;
        frame_ready = 1'b0;
        expPsumValid = 1'b0;
        expPsum      = 8'h00;

        // Reset held two cycles while a node is offered.
        applyStimulus("reset0", 1, 0, 1, 8'hA5, 0);
        applyStimulus("reset1", 1, 0, 1, 8'h5A, 0);

        // Single-node partial sums, each followed by an idle cycle.
        psumVec = '{8'h80, 8'h01, 8'h03, 8'hFF};
        foreach (psumVec[i]) begin
            applyStimulus("psum_acc", 0, 0, 1, psumVec[i], 0);
            applyStimulus("psum_idle", 0, 0, 0, 8'h00, 0);
        end
        cmp("psum_ff_const", FRAME_LEN'(psum_bits), FRAME_LEN'(8'h01));
        applyStimulus("clear", 0, 1, 0, 8'h00, 0);

        // Full frame of nodes 00..07 back to back.
        for (int i = 0; i < SLOTS; i++) applyStimulus("fill", 0, 0, 1, 8'(i), 0);
        cmp("frame_const", frame_bits, 64'h0001020304050607);

        // Backpressure: frame held, offered nodes ignored, then accepted.
        for (int i = 0; i < 5; i++) applyStimulus("hold", 0, 0, 1, 8'($urandom), 0);
        applyStimulus("frame_acc", 0, 0, 0, 8'h00, 1);
        applyStimulus("post_acc", 0, 0, 0, 8'h00, 0);

        // Abort after three nodes with a node offered in the same cycle.
        for (int i = 0; i < 3; i++) applyStimulus("pre_abort", 0, 0, 1, 8'($urandom), 0);
        applyStimulus("abort", 0, 1, 1, 8'($urandom), 0);
        for (int i = 0; i < SLOTS; i++) applyStimulus("refill", 0, 0, 1, 8'($urandom), 0);
        // Start while full with frame_ready high aborts instead of accepting.
        applyStimulus("abort_full", 0, 1, 0, 8'h00, 1);

        // Mid-frame reset after five nodes, then a fresh full frame.
        for (int i = 0; i < 5; i++) applyStimulus("pre_rst", 0, 0, 1, 8'($urandom), 0);
        applyStimulus("mid_rst", 1, 0, 1, 8'($urandom), 0);
        for (int i = 0; i < SLOTS; i++) applyStimulus("after_rst", 0, 0, 1, 8'($urandom), 0);
        applyStimulus("after_rst_acc", 0, 0, 1, 8'($urandom), 1);

        // Randomized traffic with occasional aborts and resets.
        for (int i = 0; i < 300; i++) begin
            applyStimulus("rand",
                          ($urandom_range(0, 99) < 2),
                          ($urandom_range(0, 99) < 5),
                          ($urandom_range(0, 99) < 70),
                          8'($urandom),
                          ($urandom_range(0, 99) < 50));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
